// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: text base, i-cache line geometry and fetch FSM encoding.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_W     = LINE_WORDS * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/i_fetch_ctrl_if.sv
// Fetch-control bus: i-cache request/response plus decode handoff.
// IFETCH_STATS_EN adds the statistics counter outputs.
interface i_fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 4
);
  import riscv_pkg::*;

  logic [DATA_WIDTH-1:0]            cache_pc;
  logic                             cache_rd_en;
  logic                             cache_abort;
  logic [LINE_WORDS*DATA_WIDTH-1:0] cache_dout;
  logic                             cache_dout_valid;
  logic [DATA_WIDTH-1:0]            instr;
  logic [DATA_WIDTH-1:0]            instr_pc;
  logic                             instr_valid;
  logic                             instr_ready;
  logic                             flush;
  logic [DATA_WIDTH-1:0]            flush_pc;
  logic [CNT_W-1:0]                 q_count;

`ifdef IFETCH_STATS_EN
  logic [31:0] stat_lines;
  logic [31:0] stat_flushes;
  logic [31:0] stat_stall_cycles;

  modport master (
    output cache_pc, cache_rd_en, cache_abort, instr, instr_pc, instr_valid, q_count,
    output stat_lines, stat_flushes, stat_stall_cycles,
    input  cache_dout, cache_dout_valid, instr_ready, flush, flush_pc
  );
  modport slave (
    input  cache_pc, cache_rd_en, cache_abort, instr, instr_pc, instr_valid, q_count,
    input  stat_lines, stat_flushes, stat_stall_cycles,
    output cache_dout, cache_dout_valid, instr_ready, flush, flush_pc
  );
`else
  modport master (
    output cache_pc, cache_rd_en, cache_abort, instr, instr_pc, instr_valid, q_count,
    input  cache_dout, cache_dout_valid, instr_ready, flush, flush_pc
  );
  modport slave (
    input  cache_pc, cache_rd_en, cache_abort, instr, instr_pc, instr_valid, q_count,
    output cache_dout, cache_dout_valid, instr_ready, flush, flush_pc
  );
`endif

endinterface

// File: rtl/ifetch_queue.sv
// Circular {pc,instr} buffer: accepts the tail of one i-cache line per cycle
// (words first..3), pops one entry per cycle, synchronous clear wins over both.
module ifetch_queue #(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  DEPTH      = 8,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clr,
  input  logic                                        push,
  input  logic [1:0]                                  first,
  input  logic [DATA_WIDTH-5:0]                       line_tag,
  input  logic [riscv_pkg::LINE_WORDS*DATA_WIDTH-1:0] line_data,
  input  logic                                        pop,
  output logic [DATA_WIDTH-1:0]                       head_instr,
  output logic [DATA_WIDTH-1:0]                       head_pc,
  output logic [CNT_W-1:0]                            count
);
  import riscv_pkg::*;

  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [2:0]            n_words;

  assign n_words = push ? 3'(LINE_WORDS) - {1'b0, first} : 3'd0;

  // Word k of the line lands (k - first) slots past the write pointer.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        if (k >= 32'(first)) begin
          pc_mem[wr_ptr + PTR_W'(k) - PTR_W'(first)]    <= {line_tag, 2'(k), 2'b00};
          instr_mem[wr_ptr + PTR_W'(k) - PTR_W'(first)] <= line_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_words);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(n_words) - CNT_W'(pop);
    end
  end

  assign head_instr = (count == '0) ? '0 : instr_mem[rd_ptr];
  assign head_pc    = (count == '0) ? '0 : pc_mem[rd_ptr];

endmodule

// File: rtl/i_fetch_ctrl.sv
// Instruction fetch sequencer: requests 16-byte lines from the i-cache and feeds decode.
// Define IFETCH_STATS_EN to add saturating line/flush/stall counters.
module i_fetch_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = riscv_pkg::RESET_PC,
  parameter int unsigned           QUEUE_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  i_fetch_ctrl_if.master bus
);
  import riscv_pkg::*;

  localparam int unsigned      CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(QUEUE_DEPTH - LINE_WORDS);

  fetch_state_e          state;
  fetch_state_e          state_nx;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] fetch_pc_nx;
  logic                  rd_en;
  logic                  rd_en_nx;
  logic                  abort;
  logic                  abort_nx;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nx;
  logic [2:0]            n_push;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [DATA_WIDTH-1:0] head_pc;

  // A flush in the same cycle drops the returning line and any pop.
  assign push     = rd_en & bus.cache_dout_valid & ~bus.flush;
  assign pop      = (count != '0) & bus.instr_ready & ~bus.flush;
  assign n_push   = push ? 3'(LINE_WORDS) - {1'b0, fetch_pc[3:2]} : 3'd0;
  assign count_nx = bus.flush ? '0 : count + CNT_W'(n_push) - CNT_W'(pop);

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    rd_en_nx    = 1'b0;
    abort_nx    = 1'b0;
    if (bus.flush) begin
      state_nx    = REQ;
      fetch_pc_nx = bus.flush_pc;
      abort_nx    = (state == WAIT) || rd_en;
    end else begin
      case (state)
        IDLE:    state_nx = REQ;
        REQ:     if (rd_en && !bus.cache_dout_valid) state_nx = WAIT;
        WAIT:    if (bus.cache_dout_valid) state_nx = REQ;
        default: state_nx = IDLE;
      endcase
      if (push) fetch_pc_nx = {fetch_pc[DATA_WIDTH-1:4], 4'h0} + DATA_WIDTH'(LINE_BYTES);
    end
    // Request is registered: decide from next state and next occupancy.
    rd_en_nx = (state_nx == WAIT) || ((state_nx == REQ) && (count_nx <= REQ_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_en    <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      rd_en    <= rd_en_nx;
      abort    <= abort_nx;
    end
  end

  ifetch_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.flush),
    .push       (push),
    .first      (fetch_pc[3:2]),
    .line_tag   (fetch_pc[DATA_WIDTH-1:4]),
    .line_data  (bus.cache_dout),
    .pop        (pop),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign bus.cache_pc    = {fetch_pc[DATA_WIDTH-1:4], 4'h0};
  assign bus.cache_rd_en = rd_en;
  assign bus.cache_abort = abort;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.q_count     = count;

`ifdef IFETCH_STATS_EN
  logic [31:0] n_lines;
  logic [31:0] n_flushes;
  logic [31:0] n_stalls;

  // Stall = REQ cycle with the request held back by a nearly full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lines   <= '0;
      n_flushes <= '0;
      n_stalls  <= '0;
    end else begin
      if (push && (n_lines != '1)) n_lines <= n_lines + 32'd1;
      if (bus.flush && (n_flushes != '1)) n_flushes <= n_flushes + 32'd1;
      if ((state == REQ) && !rd_en && (n_stalls != '1)) n_stalls <= n_stalls + 32'd1;
    end
  end

  assign bus.stat_lines        = n_lines;
  assign bus.stat_flushes      = n_flushes;
  assign bus.stat_stall_cycles = n_stalls;
`endif

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Bench for i_fetch_ctrl: directed table, hand-written corner sequences and
// randomized traffic against a queue-based reference model with a variable-latency cache.
module tb_i_fetch_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i_fetch_ctrl_if #(.DATA_WIDTH(32), .CNT_W(4)) bus ();

  i_fetch_ctrl #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0040_0000),
    .QUEUE_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rd;
    logic [31:0] cpc;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] cnt;
  } row_t;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_waiting;
  bit          m_abort;
  int          lat;
  int          lat_cnt;

  int vectors;
  int miscompares;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = word_at(base + 32'(4 * k));
    return l;
  endfunction

  function automatic bit exp_rd();
    return m_started && (m_waiting || ((8 - mq.size()) >= 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare against the model, drive inputs, advance the model.
  task automatic cycle(input bit ready, input bit fl, input logic [31:0] fpc);
    bit          e_rd;
    bit          dv;
    logic [31:0] base;
    e_rd = exp_rd();
    base = {m_pc[31:4], 4'h0};
    chk("rd_en",    32'(bus.cache_rd_en), 32'(e_rd));
    chk("cache_pc", bus.cache_pc, base);
    chk("abort",    32'(bus.cache_abort), 32'(m_abort));
    chk("valid",    32'(bus.instr_valid), 32'(mq.size() != 0));
    chk("instr_pc", bus.instr_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("instr",    bus.instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk("q_count",  32'(bus.q_count), 32'(mq.size()));

    dv = e_rd && (lat_cnt >= lat);
    bus.cache_dout_valid = dv;
    bus.cache_dout       = dv ? line_of(base) : {$urandom, $urandom, $urandom, $urandom};
    bus.instr_ready      = ready;
    bus.flush            = fl;
    bus.flush_pc         = fpc;

    if (fl) begin
      m_abort   = m_waiting || e_rd;
      mq.delete();
      m_pc      = fpc;
      m_started = 1'b1;
      m_waiting = 1'b0;
      lat_cnt   = 0;
    end else begin
      m_abort = 1'b0;
      if (ready && mq.size() != 0) void'(mq.pop_front());
      if (!m_started) begin
        m_started = 1'b1;
      end else if (e_rd && dv) begin
        for (int k = int'(m_pc[3:2]); k < 4; k++) begin
          logic [31:0] a;
          a = {m_pc[31:4], k[1:0], 2'b00};
          mq.push_back('{pc: a, instr: word_at(a)});
        end
        m_pc      = base + 32'd16;
        m_waiting = 1'b0;
        lat_cnt   = 0;
      end else if (e_rd) begin
        m_waiting = 1'b1;
        lat_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset; outputs are checked while reset is still asserted.
  task automatic do_reset();
    rst = 1'b1;
    bus.cache_dout_valid = 1'b0;
    bus.cache_dout       = '0;
    bus.instr_ready      = 1'b0;
    bus.flush            = 1'b0;
    bus.flush_pc         = '0;
    #1;
    chk("rst_rd_en",    32'(bus.cache_rd_en), 32'h0);
    chk("rst_abort",    32'(bus.cache_abort), 32'h0);
    chk("rst_valid",    32'(bus.instr_valid), 32'h0);
    chk("rst_q_count",  32'(bus.q_count), 32'h0);
    chk("rst_instr",    bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_cache_pc", bus.cache_pc, 32'h0040_0000);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    mq.delete();
    m_pc      = 32'h0040_0000;
    m_started = 1'b0;
    m_waiting = 1'b0;
    m_abort   = 1'b0;
    lat_cnt   = 0;
  endtask

  row_t tbl[11];

  initial begin
    vectors     = 0;
    miscompares = 0;
    lat         = 0;
    rst         = 1'b0;
    #1;

    // Zero-latency cache, decode always ready: expected stream from reset.
    tbl[0]  = '{1'b0, 32'h0040_0000, 1'b0, 32'h0,          32'd0};
    tbl[1]  = '{1'b1, 32'h0040_0000, 1'b0, 32'h0,          32'd0};
    tbl[2]  = '{1'b1, 32'h0040_0010, 1'b1, 32'h0040_0000, 32'd4};
    tbl[3]  = '{1'b0, 32'h0040_0020, 1'b1, 32'h0040_0004, 32'd7};
    tbl[4]  = '{1'b0, 32'h0040_0020, 1'b1, 32'h0040_0008, 32'd6};
    tbl[5]  = '{1'b0, 32'h0040_0020, 1'b1, 32'h0040_000C, 32'd5};
    tbl[6]  = '{1'b1, 32'h0040_0020, 1'b1, 32'h0040_0010, 32'd4};
    tbl[7]  = '{1'b0, 32'h0040_0030, 1'b1, 32'h0040_0014, 32'd7};
    tbl[8]  = '{1'b0, 32'h0040_0030, 1'b1, 32'h0040_0018, 32'd6};
    tbl[9]  = '{1'b0, 32'h0040_0030, 1'b1, 32'h0040_001C, 32'd5};
    tbl[10] = '{1'b1, 32'h0040_0030, 1'b1, 32'h0040_0020, 32'd4};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk("tbl_rd_en",    32'(bus.cache_rd_en), 32'(tbl[i].rd));
      chk("tbl_cache_pc", bus.cache_pc, tbl[i].cpc);
      chk("tbl_valid",    32'(bus.instr_valid), 32'(tbl[i].v));
      chk("tbl_instr_pc", bus.instr_pc, tbl[i].ipc);
      chk("tbl_q_count",  32'(bus.q_count), tbl[i].cnt);
      cycle(1'b1, 1'b0, 32'h0);
    end

    // Decode stalled: queue fills with two lines and the request drops.
    do_reset();
    repeat (12) cycle(1'b0, 1'b0, 32'h0);
    chk("full_q_count", 32'(bus.q_count), 32'd8);
    chk("full_rd_en",   32'(bus.cache_rd_en), 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    chk("refill_rd_en",    32'(bus.cache_rd_en), 32'h1);
    chk("refill_cache_pc", bus.cache_pc, 32'h0040_0020);
    chk("refill_q_count",  32'(bus.q_count), 32'd4);

    // Three-cycle cache latency, then a redirect while waiting on the next line.
    do_reset();
    lat = 3;
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("lat3_rd_en",    32'(bus.cache_rd_en), 32'h1);
    chk("lat3_cache_pc", bus.cache_pc, 32'h0040_0000);
    chk("lat3_q_count",  32'(bus.q_count), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("lat3_push_cnt", 32'(bus.q_count), 32'd4);
    cycle(1'b0, 1'b0, 32'h0);
    chk("wait_rd_en", 32'(bus.cache_rd_en), 32'h1);
    cycle(1'b0, 1'b1, 32'h0040_0018);
    chk("flush_abort",    32'(bus.cache_abort), 32'h1);
    chk("flush_q_count",  32'(bus.q_count), 32'd0);
    chk("flush_cache_pc", bus.cache_pc, 32'h0040_0010);
    lat = 0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("unaligned_cnt",   32'(bus.q_count), 32'd2);
    chk("unaligned_pc",    bus.instr_pc, 32'h0040_0018);
    chk("abort_one_cycle", 32'(bus.cache_abort), 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // Flush coincident with returning line and a pop; then 32-bit wrap.
    do_reset();
    lat = 0;
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    chk("coinc_pre_cnt", 32'(bus.q_count), 32'd4);
    cycle(1'b1, 1'b1, 32'h0040_0100);
    chk("coinc_q_count", 32'(bus.q_count), 32'd0);
    chk("coinc_abort",   32'(bus.cache_abort), 32'h1);
    chk("coinc_valid",   32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redirect_valid", 32'(bus.instr_valid), 32'h1);
    chk("redirect_pc",    bus.instr_pc, 32'h0040_0100);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF0);
    chk("wrap_req_pc", bus.cache_pc, 32'hFFFF_FFF0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_next_pc",  bus.cache_pc, 32'h0000_0000);
    chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFF0);

    // Randomized traffic: variable latency, bursty decode, occasional redirects.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit          r;
      bit          f;
      logic [31:0] fp;
      if (n == 1500) do_reset();
      if (!m_waiting) lat = $urandom_range(0, 3);
      r  = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 24) == 0);
      fp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C))
                                       : ($urandom & 32'hFFFF_FFFC);
      cycle(r, f, fp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
